// File: rtl/shift_result_fifo_if.sv
// Handshake/status bundle for shift_result_fifo.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface shift_result_fifo_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_valid;
  logic          o_ready;
  logic [N-1:0]  i_data;
  logic          i_err;
  logic          i_ovf;
  logic          o_valid;
  logic          i_ready;
  logic [N-1:0]  o_data;
  logic          o_err;
  logic          o_ovf;
  logic [CW-1:0] o_count;
  logic          o_sticky_err;
  logic          o_sticky_ovf;
  logic          i_clr_flags;
  logic [CNT_W-1:0] o_err_cnt;

  modport slave (
    input  i_valid, i_data, i_err, i_ovf, i_ready, i_clr_flags,
    output o_ready, o_valid, o_data, o_err, o_ovf, o_count,
           o_sticky_err, o_sticky_ovf, o_err_cnt
  );

  modport master (
    output i_valid, i_data, i_err, i_ovf, i_ready, i_clr_flags,
    input  o_ready, o_valid, o_data, o_err, o_ovf, o_count,
           o_sticky_err, o_sticky_ovf, o_err_cnt
  );
endinterface

// File: rtl/shift_result_fifo.sv
// Registered output stage behind the sign-magnitude shifter: DEPTH-entry FIFO of
// {err, ovf, data} with sticky error/overflow flags and a saturating error counter.
// Optional macro SHIFT_RESULT_U2_CONV_EN: head data is presented as two's complement
// (stored entries stay sign-magnitude). Without it head data is raw.
// Interface parameters must match the module parameters.
module shift_result_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  shift_result_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = N + 2;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sticky_err_q, sticky_err_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic full, empty, push, pop;
  logic [EW-1:0] head;
  logic [N-1:0]  head_data;

  // Occupancy decoded only from registered count: no input-to-output comb path.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.i_valid & ~full;
  assign pop   = ~empty & bus.i_ready;

  // Next-state for pointers, occupancy and status path.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // A flagged push in the same cycle as a clear wins over the clear.
    sticky_err_d = (sticky_err_q & ~bus.i_clr_flags) | (push & bus.i_err);
    sticky_ovf_d = (sticky_ovf_q & ~bus.i_clr_flags) | (push & bus.i_ovf);
    err_cnt_d    = bus.i_clr_flags ? '0 : err_cnt_q;
    if (push && bus.i_err) begin
      if (bus.i_clr_flags)        err_cnt_d = CNT_W'(1);
      else if (!(&err_cnt_q))     err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Control/status registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sticky_err_q <= 1'b0;
      sticky_ovf_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sticky_err_q <= sticky_err_d;
      sticky_ovf_q <= sticky_ovf_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Storage array; contents are don't-care until written, output is gated by o_valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.i_err, bus.i_ovf, bus.i_data};
  end

  assign head = mem_q[rd_ptr_q];

  // Head data formatting (raw or sign-magnitude -> two's complement).
  always_comb begin
`ifdef SHIFT_RESULT_U2_CONV_EN
    logic [N-1:0] mag;
    mag       = {1'b0, head[N-2:0]};
    head_data = head[N-1] ? (~mag + N'(1)) : mag;   // -0 folds to 0 naturally
`else
    head_data = head[N-1:0];
`endif
  end

  assign bus.o_ready      = ~full;
  assign bus.o_valid      = ~empty;
  assign bus.o_data       = empty ? '0 : head_data;
  assign bus.o_err        = ~empty & head[N+1];
  assign bus.o_ovf        = ~empty & head[N];
  assign bus.o_count      = count_q;
  assign bus.o_sticky_err = sticky_err_q;
  assign bus.o_sticky_ovf = sticky_ovf_q;
  assign bus.o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_shift_result_fifo.sv
// Directed table-driven bench for shift_result_fifo (N=8, DEPTH=4, CNT_W=4).
module tb_shift_result_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_result_fifo_if #(.N(8), .DEPTH(4), .CNT_W(4)) bus ();
  shift_result_fifo #(.N(8), .DEPTH(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rd;
    logic       ev;
    logic       erdy;
    logic [7:0] ed;   // raw sign-magnitude head expected
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rd,
                              input logic ev, input logic erdy, input logic [7:0] ed,
                              input logic [2:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.rd = rd; t.ev = ev; t.erdy = erdy; t.ed = ed; t.ec = ec;
    return t;
  endfunction

  // Expected presentation of a raw head value.
  function automatic logic [7:0] exp_d(input logic [7:0] r);
`ifdef SHIFT_RESULT_U2_CONV_EN
    logic [7:0] m;
    m = {1'b0, r[6:0]};
    return r[7] ? (~m + 8'd1) : m;
`else
    return r;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic o,
                       input logic rd, input logic clr);
    bus.i_valid = v; bus.i_data = d; bus.i_err = e; bus.i_ovf = o;
    bus.i_ready = rd; bus.i_clr_flags = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in-order fill, hold-off when full, drain, then the 5th entry
    tbl[0]  = mk(1, 8'h85, 0, 1, 1, 8'h85, 1);
    tbl[1]  = mk(1, 8'h01, 0, 1, 1, 8'h85, 2);
    tbl[2]  = mk(1, 8'h02, 0, 1, 1, 8'h85, 3);
    tbl[3]  = mk(1, 8'h03, 0, 1, 0, 8'h85, 4);
    tbl[4]  = mk(1, 8'h04, 0, 1, 0, 8'h85, 4);
    tbl[5]  = mk(1, 8'h04, 1, 1, 1, 8'h01, 3);
    tbl[6]  = mk(1, 8'h04, 1, 1, 1, 8'h02, 3);
    tbl[7]  = mk(0, 8'h00, 1, 1, 1, 8'h03, 2);
    tbl[8]  = mk(0, 8'h00, 1, 1, 1, 8'h04, 1);
    tbl[9]  = mk(0, 8'h00, 1, 0, 1, 8'h00, 0);
    // count=2 with simultaneous push/pop across pointer wrap
    tbl[10] = mk(1, 8'h10, 0, 1, 1, 8'h10, 1);
    tbl[11] = mk(1, 8'h11, 0, 1, 1, 8'h10, 2);
    tbl[12] = mk(1, 8'h12, 1, 1, 1, 8'h11, 2);
    tbl[13] = mk(1, 8'h13, 1, 1, 1, 8'h12, 2);
    tbl[14] = mk(1, 8'h14, 1, 1, 1, 8'h13, 2);
    tbl[15] = mk(0, 8'h00, 1, 1, 1, 8'h14, 1);
    tbl[16] = mk(0, 8'h00, 1, 0, 1, 8'h00, 0);
    // conversion corner values
    tbl[17] = mk(1, 8'h80, 0, 1, 1, 8'h80, 1);
    tbl[18] = mk(1, 8'hFF, 1, 1, 1, 8'hFF, 1);
    tbl[19] = mk(1, 8'h7F, 1, 1, 1, 8'h7F, 1);
    tbl[20] = mk(0, 8'h00, 1, 0, 1, 8'h00, 0);

    drive(0, 8'h00, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid",  bus.o_valid, 0);
    chk("rst_ready",  bus.o_ready, 1);
    chk("rst_count",  bus.o_count, 0);
    chk("rst_data",   bus.o_data, 0);
    chk("rst_flags",  {bus.o_sticky_err, bus.o_sticky_ovf, bus.o_err, bus.o_ovf}, 0);
    chk("rst_errcnt", bus.o_err_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].d, 0, 0, tbl[i].rd, 0);
      tick();
      chk($sformatf("v%0d_valid", i), bus.o_valid, tbl[i].ev);
      chk($sformatf("v%0d_ready", i), bus.o_ready, tbl[i].erdy);
      chk($sformatf("v%0d_count", i), bus.o_count, tbl[i].ec);
      chk($sformatf("v%0d_data", i),  bus.o_data, exp_d(tbl[i].ed));
    end

    // sticky flags, counter, clear vs. concurrent flagged push
    drive(1, 8'h22, 0, 1, 1, 0); tick();
    chk("ovf_sticky", {bus.o_sticky_err, bus.o_sticky_ovf}, 2'b01);
    chk("ovf_head",   {bus.o_err, bus.o_ovf}, 2'b01);
    chk("ovf_cnt",    bus.o_err_cnt, 0);
    drive(1, 8'h00, 1, 0, 1, 0); tick();
    chk("err_sticky", {bus.o_sticky_err, bus.o_sticky_ovf}, 2'b11);
    chk("err_head",   {bus.o_err, bus.o_ovf}, 2'b10);
    chk("err_cnt",    bus.o_err_cnt, 1);
    drive(1, 8'h00, 1, 0, 1, 1); tick();
    chk("clrpush_sticky", {bus.o_sticky_err, bus.o_sticky_ovf}, 2'b10);
    chk("clrpush_cnt",    bus.o_err_cnt, 1);
    drive(0, 8'h00, 0, 0, 1, 1); tick();
    chk("clr_sticky", {bus.o_sticky_err, bus.o_sticky_ovf}, 2'b00);
    chk("clr_cnt",    bus.o_err_cnt, 0);
    chk("clr_empty",  bus.o_count, 0);
    drive(0, 8'h00, 0, 0, 1, 0);

    // counter saturation
    for (int i = 0; i < 17; i++) begin
      drive(1, 8'h00, 1, 0, 1, 0); tick();
    end
    chk("sat_cnt",   bus.o_err_cnt, 15);
    chk("sat_count", bus.o_count, 1);
    drive(0, 8'h00, 0, 0, 1, 0); tick();
    chk("sat_hold",  bus.o_err_cnt, 15);

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h30 + i), 0, 1, 0, 0); tick();
    end
    chk("pre_rst_count", bus.o_count, 3);
    drive(0, 8'h00, 0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_count", bus.o_count, 0);
    chk("mid_rst_flags", {bus.o_sticky_err, bus.o_sticky_ovf}, 0);
    chk("mid_rst_cnt",   bus.o_err_cnt, 0);
    chk("mid_rst_data",  bus.o_data, 0);

    // after reset, a fresh push appears at head with the right value
    drive(1, 8'h85, 0, 0, 0, 0); tick();
    chk("post_rst_data",  bus.o_data, exp_d(8'h85));
    chk("post_rst_count", bus.o_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
